// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-write-port register file.
package rf_pkg;

   typedef enum logic [0:0] {
      RF_SCRUB = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   // An address can be written or read back only if it maps to a real,
   // non-hardwired entry.
   function automatic logic rf_addr_valid(input logic [31:0] addr,
                                          input logic [31:0] size,
                                          input logic        zero_reg);
      return (addr < size) && !(zero_reg && (addr == 32'd0));
   endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Combinational write arbitration: per-entry enable and winning data, plus
// a flag for two or more enabled ports hitting the same valid entry.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int SIZE        = 64,
   parameter int WRITE_PORTS = 2,
   parameter int ZERO_REG    = 1
) (
   input  logic [WRITE_PORTS-1:0]                 i_write_en,
   input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] i_write_addr,
   input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] i_write_data,
   output logic [SIZE-1:0]                        o_we,
   output logic [SIZE-1:0][DATA_WIDTH-1:0]        o_wdata,
   output logic                                   o_conflict
);

   always_comb begin
      // NOTE: every output gets a default before the loops so no path can
      // leave one unassigned and infer a latch.
      o_we       = '0;
      o_wdata    = '0;
      o_conflict = 1'b0;
      for (int e = 0; e < SIZE; e++) begin
         if (rf_addr_valid(32'(e), 32'(SIZE), ZERO_REG != 0)) begin
            // Ascending scan: a later (higher-index) port overwrites earlier ones.
            for (int p = 0; p < WRITE_PORTS; p++) begin
               if (i_write_en[p] && (i_write_addr[p] == ADDR_WIDTH'(e))) begin
                  if (o_we[e]) begin
                     o_conflict = 1'b1;
                  end
                  o_we[e]    = 1'b1;
                  o_wdata[e] = i_write_data[p];
               end
            end
         end
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-write-port register file with bypass, optional zero register and a
// sequential scrub engine that clears every entry after reset or on request.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int SIZE        = 64,
   parameter int READ_PORTS  = 4,
   parameter int WRITE_PORTS = 2,
   parameter int BYPASS      = 1,
   parameter int ZERO_REG    = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   init_req,
   output logic                                   ready,
   input  logic [WRITE_PORTS-1:0]                 write_en,
   input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] write_addr,
   input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_data,
   input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  read_addr,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  data_out,
   output logic                                   write_conflict
);

   rf_state_e                       r_state;
   logic [ADDR_WIDTH-1:0]           r_scrub_ptr;
   logic                            r_write_conflict;
   logic [DATA_WIDTH-1:0]           r_mem [SIZE];

   logic [WRITE_PORTS-1:0]          w_write_en;
   logic [SIZE-1:0]                 w_we;
   logic [SIZE-1:0][DATA_WIDTH-1:0] w_wdata;
   logic                            w_conflict;

   // Writes are only accepted once the file is scrubbed.
   assign w_write_en = write_en & {WRITE_PORTS{r_state == RF_READY}};

   rf_write_arbiter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SIZE        (SIZE),
      .WRITE_PORTS (WRITE_PORTS),
      .ZERO_REG    (ZERO_REG)
   ) u_arbiter (
      .i_write_en   (w_write_en),
      .i_write_addr (write_addr),
      .i_write_data (write_data),
      .o_we         (w_we),
      .o_wdata      (w_wdata),
      .o_conflict   (w_conflict)
   );

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= RF_SCRUB;
         r_scrub_ptr      <= '0;
         r_write_conflict <= 1'b0;
      end else begin
         r_write_conflict <= w_conflict;
         case (r_state)
            RF_SCRUB: begin
               if (r_scrub_ptr == ADDR_WIDTH'(SIZE - 1)) begin
                  r_state     <= RF_READY;
                  r_scrub_ptr <= '0;
               end else begin
                  r_scrub_ptr <= r_scrub_ptr + 1'b1;
               end
            end
            RF_READY: begin
               if (init_req) begin
                  r_state     <= RF_SCRUB;
                  r_scrub_ptr <= '0;
               end
            end
         endcase
      end
   end

   // NOTE: the array has no reset; clearing it is the scrub engine's job,
   // which keeps it mappable onto plain RAM or flop banks without reset.
   always_ff @(posedge clk) begin
      if (r_state == RF_SCRUB) begin
         r_mem[r_scrub_ptr] <= '0;
      end else begin
         for (int e = 0; e < SIZE; e++) begin
            if (w_we[e]) begin
               r_mem[e] <= w_wdata[e];
            end
         end
      end
   end

   always_comb begin
      data_out = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         if ((r_state == RF_READY) &&
             rf_addr_valid(32'(read_addr[r]), 32'(SIZE), ZERO_REG != 0)) begin
            if ((BYPASS != 0) && w_we[read_addr[r]]) begin
               data_out[r] = w_wdata[read_addr[r]];
            end else begin
               data_out[r] = r_mem[read_addr[r]];
            end
         end
      end
   end

   assign ready          = (r_state == RF_READY);
   assign write_conflict = r_write_conflict;

endmodule
